// File: rtl/tube_r3_dma_ctrl.sv
// Tube register 3 block-transfer sequencer (parasite side).
// Moves cfg_len bytes between parasite memory and tube FIFO register 3,
// servicing one (V=0) or two (V=1) bytes per synchronised PNMI request.
module tube_r3_dma_ctrl #(
  parameter int unsigned AW          = 16,
  parameter int unsigned LW          = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          p_phi2,
  input  logic          p_rst,
  input  logic          start,
  input  logic          cfg_dir,
  input  logic          cfg_two_byte,
  input  logic [AW-1:0] cfg_base,
  input  logic [LW-1:0] cfg_len,
  input  logic          abort,
  input  logic          t_nmi_b,
  output logic          t_cs_b,
  output logic [2:0]    t_addr,
  output logic          t_rdnw,
  output logic [7:0]    t_wdata,
  input  logic [7:0]    t_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_REQ,
    S_T_RD,
    S_M_WR,
    S_M_RD,
    S_T_WR,
    S_NEXT,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] nmi_sync_q;
  logic [AW-1:0]          addr_q;
  logic [LW-1:0]          remaining_q;
  logic [1:0]             burst_q;
  logic                   dir_q;
  logic                   two_q;
  logic                   abort_q;
  logic [7:0]             data_q;
  logic                   t_cs_b_q;
  logic                   t_rdnw_q;
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;

  logic                   nmi_req;
  logic                   abort_now;
  logic [AW-1:0]          addr_d;
  logic [LW-1:0]          remaining_d;
  logic [1:0]             burst_d;

  // Request/abort qualification and per-byte counter arithmetic.
  always_comb begin
    nmi_req     = ~nmi_sync_q[SYNC_STAGES-1];
    abort_now   = abort | abort_q;
    addr_d      = addr_q + AW'(1);
    remaining_d = remaining_q - LW'(1);
    burst_d     = burst_q - 2'd1;
  end

  // PNMI synchroniser; idle (high) out of reset.
  always_ff @(posedge p_phi2 or posedge p_rst) begin
    if (p_rst) begin
      nmi_sync_q <= '1;
    end else begin
      nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], t_nmi_b};
    end
  end

  // Transfer sequencer; every bus output is registered and set on entry to
  // the state that owns it. An abort is remembered in abort_q so an in-flight
  // memory cycle or tube strobe finishes before the sequencer heads to DONE.
  always_ff @(posedge p_phi2 or posedge p_rst) begin
    if (p_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      dir_q       <= 1'b0;
      two_q       <= 1'b0;
      abort_q     <= 1'b0;
      data_q      <= '0;
      t_cs_b_q    <= 1'b1;
      t_rdnw_q    <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != S_IDLE && state_q != S_DONE) begin
        abort_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (start) begin
            if (cfg_len == '0 || (cfg_two_byte && cfg_len[0])) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              addr_q      <= cfg_base;
              remaining_q <= cfg_len;
              dir_q       <= cfg_dir;
              two_q       <= cfg_two_byte;
              err_q       <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= S_ARM;
            end
          end
        end
        S_ARM: begin
          if (abort_now) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_WAIT_REQ;
          end
        end
        S_WAIT_REQ: begin
          if (abort_now) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (nmi_req) begin
            burst_q <= two_q ? 2'd2 : 2'd1;
            if (dir_q) begin
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              state_q   <= S_M_RD;
            end else begin
              t_cs_b_q <= 1'b0;
              t_rdnw_q <= 1'b1;
              state_q  <= S_T_RD;
            end
          end
        end
        S_T_RD: begin
          data_q    <= t_rdata;
          t_cs_b_q  <= 1'b1;
          mem_req_q <= 1'b1;
          mem_we_q  <= 1'b1;
          state_q   <= S_M_WR;
        end
        S_M_WR: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= S_NEXT;
          end
        end
        S_M_RD: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            data_q    <= mem_rdata;
            if (abort_now) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              t_cs_b_q <= 1'b0;
              t_rdnw_q <= 1'b0;
              state_q  <= S_T_WR;
            end
          end
        end
        S_T_WR: begin
          t_cs_b_q <= 1'b1;
          t_rdnw_q <= 1'b1;
          state_q  <= S_NEXT;
        end
        S_NEXT: begin
          addr_q      <= addr_d;
          remaining_q <= remaining_d;
          burst_q     <= burst_d;
          if (remaining_d == '0 || abort_now) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (burst_d != 2'd0) begin
            if (dir_q) begin
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              state_q   <= S_M_RD;
            end else begin
              t_cs_b_q <= 1'b0;
              t_rdnw_q <= 1'b1;
              state_q  <= S_T_RD;
            end
          end else begin
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (abort_now) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (!nmi_req) begin
            state_q <= S_WAIT_REQ;
          end
        end
        S_DONE: begin
          abort_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign t_cs_b    = t_cs_b_q;
  assign t_addr    = 3'h5;
  assign t_rdnw    = t_rdnw_q;
  assign t_wdata   = data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tube_r3_dma_ctrl.sv
// Bench for tube_r3_dma_ctrl: acts as tube FIFO and parasite memory, drives
// PNMI bursts, and compares observed transfers with an expected byte stream.
module tb_tube_r3_dma_ctrl;

  logic        p_phi2 = 1'b0;
  logic        p_rst;
  logic        start, cfg_dir, cfg_two_byte, abort, t_nmi_b;
  logic [15:0] cfg_base, cfg_len;
  logic        t_cs_b, t_rdnw, mem_req, mem_we, mem_ack, busy, done, err;
  logic [2:0]  t_addr;
  logic [7:0]  t_wdata, t_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  always #5 p_phi2 = ~p_phi2;

  tube_r3_dma_ctrl #(.AW(16), .LW(16), .SYNC_STAGES(2)) dut (
    .p_phi2(p_phi2), .p_rst(p_rst), .start(start), .cfg_dir(cfg_dir),
    .cfg_two_byte(cfg_two_byte), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .abort(abort), .t_nmi_b(t_nmi_b), .t_cs_b(t_cs_b), .t_addr(t_addr),
    .t_rdnw(t_rdnw), .t_wdata(t_wdata), .t_rdata(t_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Environment state
  logic [7:0]  mem [int];
  logic [7:0]  tube_src[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  pre_data[$];
  logic [7:0]  tube_wr_q[$];
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int rd_idx, tube_rd_cnt, tube_wr_cnt, done_cnt, req_cnt;
  int ack_delay, wait_cnt;
  logic req_prev, cs_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int tube_cnt();
    return tube_rd_cnt + tube_wr_cnt;
  endfunction

  // Tube/memory responder plus bus-protocol monitor, sampled on the falling edge.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; t_rdata = '0;
    req_prev = 1'b0; cs_prev = 1'b0; wait_cnt = 0;
    forever begin
      @(negedge p_phi2);
      if (p_rst) begin
        mem_ack = 1'b0; req_prev = 1'b0; cs_prev = 1'b0; wait_cnt = 0;
        continue;
      end
      // A request must hold until acked and drop right after the ack.
      if (req_prev) check("mem_req_handshake", mem_req, !mem_ack);
      if (!t_cs_b) begin
        check("t_cs_b_gap", cs_prev, 1'b0);
        check("t_addr", t_addr, 3'h5);
        if (t_rdnw) begin
          t_rdata = (rd_idx < tube_src.size()) ? tube_src[rd_idx] : 8'hEE;
          rd_idx++;
          tube_rd_cnt++;
        end else begin
          tube_wr_q.push_back(t_wdata);
          tube_wr_cnt++;
        end
      end
      cs_prev = !t_cs_b;
      if (done) done_cnt++;
      if (mem_req && (!req_prev || mem_ack)) req_cnt++;
      if (mem_req && !mem_ack) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            mem[int'(mem_addr)] = mem_wdata;
          end else begin
            mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
      req_prev = mem_req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge p_phi2); #1; end
  endtask

  task automatic clear_logs();
    tube_src.delete(); exp_bytes.delete(); tube_wr_q.delete();
    wr_addr_q.delete(); wr_data_q.delete();
    rd_idx = 0; tube_rd_cnt = 0; tube_wr_cnt = 0; done_cnt = 0; req_cnt = 0;
  endtask

  task automatic do_start(input bit dir, input bit two, input logic [15:0] base,
                          input logic [15:0] len, input bit with_abort);
    cfg_dir = dir; cfg_two_byte = two; cfg_base = base; cfg_len = len;
    start = 1'b1; abort = with_abort;
    tick(1);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_tube(input int target, input string tag);
    int n = 0;
    while (tube_cnt() < target && n < 300) begin tick(1); n++; end
    check(tag, tube_cnt(), target);
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 300) begin tick(1); n++; end
    check(tag, done_cnt, target);
  endtask

  // Full transfer against the reference stream: byte i goes between tube
  // access i and memory address (base+i) mod 2^16, len/(1 or 2) PNMI bursts.
  task automatic run_xfer(input bit dir, input bit two, input logic [15:0] base,
                          input int len, input bit busy_start, input bit start_abort);
    int per;
    clear_logs();
    ack_delay = $urandom_range(0, 3);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = (pre_data.size() > i) ? pre_data[i] : 8'($urandom);
      exp_bytes.push_back(b);
      if (dir) mem[int'(16'(base + 16'(i)))] = b;
      else     tube_src.push_back(b);
    end
    pre_data.delete();
    do_start(dir, two, base, 16'(len), start_abort);
    tick(1);
    check("busy_after_start", busy, 1'b1);
    per = two ? 2 : 1;
    for (int b = 0; b < len / per; b++) begin
      tick($urandom_range(0, 4));
      t_nmi_b = 1'b0;
      if (busy_start && b == 0) begin
        do_start(~dir, 1'b0, 16'hDEAD, 16'd1, 1'b0);
      end
      wait_tube((b + 1) * per, "burst_accesses");
      t_nmi_b = 1'b1;
      if (b != len / per - 1) begin
        tick(6);
        check("quiet_while_pnmi_high", tube_cnt(), (b + 1) * per);
      end
    end
    wait_done(1, "done_pulse");
    tick(3);
    check("done_single", done_cnt, 1);
    check("busy_end", busy, 1'b0);
    check("err_clear", err, 1'b0);
    if (!dir) begin
      check("tube_reads", tube_rd_cnt, len);
      check("mem_writes", wr_addr_q.size(), len);
      for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
        check("wr_addr", wr_addr_q[i], 16'(base + 16'(i)));
        check("wr_data", wr_data_q[i], exp_bytes[i]);
      end
    end else begin
      check("tube_writes", tube_wr_cnt, len);
      check("no_mem_writes", wr_addr_q.size(), 0);
      for (int i = 0; i < len && i < tube_wr_q.size(); i++) begin
        check("tube_wdata", tube_wr_q[i], exp_bytes[i]);
      end
    end
  endtask

  initial begin
    p_rst = 1'b1; start = 1'b0; abort = 1'b0; t_nmi_b = 1'b1;
    cfg_dir = 1'b0; cfg_two_byte = 1'b0; cfg_base = '0; cfg_len = '0;
    ack_delay = 0;
    clear_logs();
    tick(3);
    check("rst_t_cs_b", t_cs_b, 1'b1);
    check("rst_t_rdnw", t_rdnw, 1'b1);
    check("rst_t_addr", t_addr, 3'h5);
    check("rst_t_wdata", t_wdata, 8'h00);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    p_rst = 1'b0;
    tick(2);

    // Host->parasite, V=0, three PNMI pulses
    pre_data.push_back(8'hA1); pre_data.push_back(8'hB2); pre_data.push_back(8'hC3);
    run_xfer(1'b0, 1'b0, 16'h2000, 3, 1'b0, 1'b0);

    // Parasite->host, V=1, two PNMI assertions
    pre_data.push_back(8'h11); pre_data.push_back(8'h22);
    pre_data.push_back(8'h33); pre_data.push_back(8'h44);
    run_xfer(1'b1, 1'b1, 16'h3000, 4, 1'b0, 1'b0);

    // Rejected starts: odd length with V=1, and zero length
    clear_logs();
    t_nmi_b = 1'b0;
    do_start(1'b0, 1'b1, 16'h1000, 16'd5, 1'b0);
    tick(3);
    check("err_odd_v1", err, 1'b1);
    check("err_done_pulse", done_cnt, 1);
    check("err_busy", busy, 1'b0);
    do_start(1'b1, 1'b0, 16'h1000, 16'd0, 1'b0);
    tick(8);
    check("err_len0", err, 1'b1);
    check("err_done_pulse2", done_cnt, 2);
    check("err_no_tube", tube_cnt(), 0);
    check("err_no_mem", req_cnt, 0);
    t_nmi_b = 1'b1;
    tick(3);

    // Valid start clears err; includes a start pulse while busy and an abort
    // coincident with the accepted start.
    run_xfer(1'b0, 1'b1, 16'h1800, 6, 1'b1, 1'b1);

    // Wrap at top of address space
    run_xfer(1'b0, 1'b0, 16'hFFFF, 2, 1'b0, 1'b0);

    // Random transfers
    for (int k = 0; k < 4; k++) begin
      bit d, v;
      int n;
      d = 1'($urandom);
      v = 1'($urandom);
      n = v ? 2 * $urandom_range(1, 3) : $urandom_range(1, 5);
      run_xfer(d, v, 16'($urandom), n, 1'b0, 1'b0);
    end

    // Held PNMI stalls in RELEASE
    clear_logs();
    ack_delay = 1;
    tube_src.push_back(8'h5A); tube_src.push_back(8'hC7);
    do_start(1'b0, 1'b0, 16'h4000, 16'd2, 1'b0);
    t_nmi_b = 1'b0;
    wait_tube(1, "held_first");
    tick(12);
    check("held_stall_low", tube_cnt(), 1);
    t_nmi_b = 1'b1;
    tick(5);
    check("held_stall_high", tube_cnt(), 1);
    t_nmi_b = 1'b0;
    wait_tube(2, "held_second");
    t_nmi_b = 1'b1;
    wait_done(1, "held_done");
    tick(2);
    check("held_wr1", (wr_data_q.size() == 2) ? wr_data_q[1] : 8'hXX, 8'hC7);

    // Abort while a slow memory write is outstanding
    clear_logs();
    ack_delay = 1;
    for (int i = 0; i < 4; i++) tube_src.push_back(8'($urandom));
    do_start(1'b0, 1'b0, 16'h5000, 16'd4, 1'b0);
    t_nmi_b = 1'b0;
    wait_tube(1, "abort_first");
    t_nmi_b = 1'b1;
    tick(6);
    ack_delay = 5;
    t_nmi_b = 1'b0;
    begin
      int n = 0;
      while (!(mem_req && tube_cnt() == 2) && n < 100) begin tick(1); n++; end
    end
    check("abort_in_mwr", mem_req, 1'b1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_req_held", mem_req, 1'b1);
    wait_done(1, "abort_done");
    tick(10);
    check("abort_writes", wr_addr_q.size(), 2);
    check("abort_wr_data", (wr_data_q.size() == 2) ? wr_data_q[1] : 8'hXX, tube_src[1]);
    check("abort_residue", dut.remaining_q, 16'd2);
    check("abort_no_more_tube", tube_cnt(), 2);
    check("abort_busy", busy, 1'b0);
    t_nmi_b = 1'b1;
    tick(3);

    // Reset while a memory read is outstanding
    clear_logs();
    ack_delay = 30;
    mem[int'(16'h6000)] = 8'h77; mem[int'(16'h6001)] = 8'h88;
    do_start(1'b1, 1'b0, 16'h6000, 16'd2, 1'b0);
    t_nmi_b = 1'b0;
    begin
      int n = 0;
      while (!mem_req && n < 50) begin tick(1); n++; end
    end
    check("rst_mrd_req", mem_req, 1'b1);
    tick(2);
    #2 p_rst = 1'b1;
    #1;
    check("rst_mid_mem_req", mem_req, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_t_cs_b", t_cs_b, 1'b1);
    check("rst_mid_mem_addr", mem_addr, 16'h0000);
    tick(2);
    p_rst = 1'b0;
    t_nmi_b = 1'b1;
    tick(4);
    check("rst_mid_after_busy", busy, 1'b0);
    check("rst_mid_no_tube", tube_cnt(), 0);

    run_xfer(1'b1, 1'b0, 16'h7000, 3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
